// File: rtl/multicycle_controller.sv
// Multicycle instruction sequencer: fetch, decode, execute, memory access,
// writeback. It drives datapath enables and guards memory waits with a timeout.
//
// state   | meaning
// --------+------------------------------------------------------------
// RESET   | datapath registers cleared; always moves on to FETCH
// FETCH   | instruction read; IR and PC load when memory is ready
// DECODE  | opcode captured into cur_op; A/B operands latched
// EXEC    | ALU step: address/result latch, or branch/jump resolution
// MEM     | load/store access; waits for memReady
// WB      | register-file write; instruction retires
// HALTED  | idle after HALT until resume
// FAULT   | illegal opcode or memory timeout; only reset leaves it
module multicycle_controller #(
    parameter int opcodeWidth = 4,
    parameter int waitLimit   = 15
) (
    input  logic                   clk,
    input  logic                   clearN,
    input  logic [opcodeWidth-1:0] opcode,
    input  logic                   zero,
    input  logic                   memReady,
    input  logic                   resume,
    output logic                   memReq,
    output logic                   memWrite,
    output logic                   irWrite,
    output logic                   pcWrite,
    output logic                   pcSrcBranch,
    output logic                   operandLatch,
    output logic                   aluOutLatch,
    output logic                   mdrLatch,
    output logic                   regFileWrite,
    output logic                   regClear,
    output logic                   instrDone,
    output logic                   busy,
    output logic                   fault,
    output logic [2:0]             state
);

    localparam int CNT_W = $clog2(waitLimit + 1);

    localparam logic [opcodeWidth-1:0] OP_NOP    = opcodeWidth'(0);
    localparam logic [opcodeWidth-1:0] OP_ALU    = opcodeWidth'(1);
    localparam logic [opcodeWidth-1:0] OP_LOAD   = opcodeWidth'(2);
    localparam logic [opcodeWidth-1:0] OP_STORE  = opcodeWidth'(3);
    localparam logic [opcodeWidth-1:0] OP_BRANCH = opcodeWidth'(4);
    localparam logic [opcodeWidth-1:0] OP_JUMP   = opcodeWidth'(5);
    localparam logic [opcodeWidth-1:0] OP_HALT   = '1;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALTED = 3'd6,
        ST_FAULT  = 3'd7
    } state_t;

    state_t                 state_q, state_d;
    logic [opcodeWidth-1:0] cur_op_q, cur_op_d;
    logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;

    logic wait_expired;
    logic mem_req, mem_write, ir_write, pc_write, pc_src_branch;
    logic operand_latch, alu_out_latch, mdr_latch, reg_file_write;
    logic reg_clear, instr_done, fault_raw;

    assign wait_expired = (wait_cnt_q == CNT_W'(waitLimit));

    // State, latched opcode and wait counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!clearN) begin
            state_q    <= ST_RESET;
            cur_op_q   <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_op_q   <= cur_op_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state and raw datapath controls from state, cur_op and inputs.
    always_comb begin
        state_d        = state_q;
        cur_op_d       = cur_op_q;
        mem_req        = 1'b0;
        mem_write      = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        pc_src_branch  = 1'b0;
        operand_latch  = 1'b0;
        alu_out_latch  = 1'b0;
        mdr_latch      = 1'b0;
        reg_file_write = 1'b0;
        reg_clear      = 1'b0;
        instr_done     = 1'b0;
        fault_raw      = 1'b0;

        case (state_q)
            ST_RESET: begin
                reg_clear = 1'b1;
                state_d   = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req = 1'b1;
                // A ready arriving on the timeout cycle still completes the fetch.
                if (memReady) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (wait_expired) begin
                    state_d = ST_FAULT;
                end
            end

            ST_DECODE: begin
                operand_latch = 1'b1;
                cur_op_d      = opcode;
                if (opcode == OP_NOP) begin
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end else if (opcode == OP_HALT) begin
                    instr_done = 1'b1;
                    state_d    = ST_HALTED;
                end else if ((opcode == OP_ALU) || (opcode == OP_LOAD) ||
                             (opcode == OP_STORE) || (opcode == OP_BRANCH) ||
                             (opcode == OP_JUMP)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FAULT;
                end
            end

            ST_EXEC: begin
                case (cur_op_q)
                    OP_ALU: begin
                        alu_out_latch = 1'b1;
                        state_d       = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_out_latch = 1'b1;
                        state_d       = ST_MEM;
                    end
                    OP_BRANCH: begin
                        pc_write      = zero;
                        pc_src_branch = zero;
                        instr_done    = 1'b1;
                        state_d       = ST_FETCH;
                    end
                    OP_JUMP: begin
                        pc_write      = 1'b1;
                        pc_src_branch = 1'b1;
                        instr_done    = 1'b1;
                        state_d       = ST_FETCH;
                    end
                    // Unreachable through DECODE; parked in FAULT if it ever happens.
                    default: state_d = ST_FAULT;
                endcase
            end

            ST_MEM: begin
                mem_req   = 1'b1;
                mem_write = (cur_op_q == OP_STORE);
                if (memReady) begin
                    if (cur_op_q == OP_LOAD) begin
                        mdr_latch = 1'b1;
                        state_d   = ST_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end else if (wait_expired) begin
                    state_d = ST_FAULT;
                end
            end

            ST_WB: begin
                reg_file_write = 1'b1;
                instr_done     = 1'b1;
                state_d        = ST_FETCH;
            end

            ST_HALTED: begin
                if (resume) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FAULT: begin
                fault_raw = 1'b1;
            end

            default: state_d = ST_RESET;
        endcase
    end

    // Wait counter: counts memory stall cycles, restarts on any state change or ready.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if ((state_d != state_q) || memReady) begin
            wait_cnt_d = '0;
        end else if ((state_q == ST_FETCH) || (state_q == ST_MEM)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Strobes that would commit work at the next edge are suppressed while
    // clearN is low, so an aborted instruction leaves nothing behind.
    assign memReq       = mem_req        & clearN;
    assign memWrite     = mem_write      & clearN;
    assign irWrite      = ir_write       & clearN;
    assign pcWrite      = pc_write       & clearN;
    assign pcSrcBranch  = pc_src_branch;
    assign operandLatch = operand_latch  & clearN;
    assign aluOutLatch  = alu_out_latch  & clearN;
    assign mdrLatch     = mdr_latch      & clearN;
    assign regFileWrite = reg_file_write & clearN;
    assign regClear     = reg_clear;
    assign instrDone    = instr_done     & clearN;
    assign fault        = fault_raw;
    assign busy         = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                          (state_q == ST_EXEC)  || (state_q == ST_MEM)    ||
                          (state_q == ST_WB);
    assign state        = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with hand-computed per-cycle
// state and output vectors.
module tb_multicycle_controller;

    logic       clk;
    logic       clearN;
    logic [3:0] opcode;
    logic       zero;
    logic       memReady;
    logic       resume;
    logic       memReq, memWrite, irWrite, pcWrite, pcSrcBranch;
    logic       operandLatch, aluOutLatch, mdrLatch, regFileWrite;
    logic       regClear, instrDone, busy, fault;
    logic [2:0] state;
    logic [12:0] outs;

    int total = 0;
    int bad   = 0;

    localparam logic [12:0] MREQ = 13'h1000;
    localparam logic [12:0] MWR  = 13'h0800;
    localparam logic [12:0] IRW  = 13'h0400;
    localparam logic [12:0] PCW  = 13'h0200;
    localparam logic [12:0] PCB  = 13'h0100;
    localparam logic [12:0] OPL  = 13'h0080;
    localparam logic [12:0] ALUL = 13'h0040;
    localparam logic [12:0] MDR  = 13'h0020;
    localparam logic [12:0] RFW  = 13'h0010;
    localparam logic [12:0] RCLR = 13'h0008;
    localparam logic [12:0] DONE = 13'h0004;
    localparam logic [12:0] BUSY = 13'h0002;
    localparam logic [12:0] FLT  = 13'h0001;
    localparam logic [12:0] FOK  = MREQ | IRW | PCW | BUSY;

    assign outs = {memReq, memWrite, irWrite, pcWrite, pcSrcBranch, operandLatch,
                   aluOutLatch, mdrLatch, regFileWrite, regClear, instrDone, busy, fault};

    multicycle_controller #(.opcodeWidth(4), .waitLimit(15)) u_dut (
        .clk          (clk),
        .clearN       (clearN),
        .opcode       (opcode),
        .zero         (zero),
        .memReady     (memReady),
        .resume       (resume),
        .memReq       (memReq),
        .memWrite     (memWrite),
        .irWrite      (irWrite),
        .pcWrite      (pcWrite),
        .pcSrcBranch  (pcSrcBranch),
        .operandLatch (operandLatch),
        .aluOutLatch  (aluOutLatch),
        .mdrLatch     (mdrLatch),
        .regFileWrite (regFileWrite),
        .regClear     (regClear),
        .instrDone    (instrDone),
        .busy         (busy),
        .fault        (fault),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clearN = 1'b0; memReady = 1'b0; resume = 1'b0; zero = 1'b0; opcode = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (state !== 3'd0 || outs !== RCLR) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d state=%0d outs=%h exp state=0 outs=%h", i, state, outs, RCLR);
            end
        end
        clearN = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || outs !== RCLR) begin
            bad++;
            $display("FAIL reset_release state=%0d outs=%h exp state=0 outs=%h", state, outs, RCLR);
        end
        tick();
        total++;
        if (state !== 3'd1 || outs !== (MREQ | BUSY)) begin
            bad++;
            $display("FAIL reset_to_fetch state=%0d outs=%h exp state=1 outs=%h", state, outs, MREQ | BUSY);
        end
    endtask

    task automatic test_alu();
        logic [2:0]  es [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
        logic [12:0] eo [5] = '{FOK, OPL | BUSY, ALUL | BUSY, RFW | DONE | BUSY, FOK};
        logic [3:0]  op [5] = '{4'd1, 4'd1, 4'hF, 4'hF, 4'd0};
        for (int i = 0; i < 5; i++) begin
            memReady = 1'b1; zero = 1'b0; opcode = op[i];
            #1;
            total++;
            if (state !== es[i]) begin
                bad++;
                $display("FAIL alu_state cyc=%0d got=%0d exp=%0d", i, state, es[i]);
            end
            total++;
            if (outs !== eo[i]) begin
                bad++;
                $display("FAIL alu_outs cyc=%0d got=%h exp=%h", i, outs, eo[i]);
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_load_wait();
        logic [2:0]  es  [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
        logic [12:0] eo  [9] = '{FOK, OPL | BUSY, ALUL | BUSY, MREQ | BUSY, MREQ | BUSY,
                                 MREQ | BUSY, MREQ | MDR | BUSY, RFW | DONE | BUSY, FOK};
        logic        rdy [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0]  op  [9] = '{4'd2, 4'd2, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'd0};
        for (int i = 0; i < 9; i++) begin
            memReady = rdy[i]; opcode = op[i];
            #1;
            total++;
            if (state !== es[i]) begin
                bad++;
                $display("FAIL load_state cyc=%0d got=%0d exp=%0d", i, state, es[i]);
            end
            total++;
            if (outs !== eo[i]) begin
                bad++;
                $display("FAIL load_outs cyc=%0d got=%h exp=%h", i, outs, eo[i]);
            end
            if (i < 8) tick();
        end
    endtask

    task automatic test_branch();
        logic [2:0]  es [7] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1};
        logic [12:0] eo [7] = '{FOK, OPL | BUSY, DONE | BUSY, FOK, OPL | BUSY,
                                PCW | PCB | DONE | BUSY, FOK};
        logic        z  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0]  op [7] = '{4'd4, 4'd4, 4'hF, 4'd4, 4'd4, 4'd0, 4'd0};
        for (int i = 0; i < 7; i++) begin
            memReady = 1'b1; zero = z[i]; opcode = op[i];
            #1;
            total++;
            if (state !== es[i]) begin
                bad++;
                $display("FAIL branch_state cyc=%0d got=%0d exp=%0d", i, state, es[i]);
            end
            total++;
            if (outs !== eo[i]) begin
                bad++;
                $display("FAIL branch_outs cyc=%0d got=%h exp=%h", i, outs, eo[i]);
            end
            if (i < 6) tick();
        end
        zero = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  es  [11] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd1, 3'd2, 3'd3, 3'd1};
        logic [12:0] eo  [11] = '{FOK, OPL | DONE | BUSY, FOK, OPL | BUSY, ALUL | BUSY,
                                  MREQ | MWR | BUSY, MREQ | MWR | DONE | BUSY, FOK,
                                  OPL | BUSY, PCW | PCB | DONE | BUSY, FOK};
        logic        rdy [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0]  op  [11] = '{4'd0, 4'd0, 4'd3, 4'd3, 4'd0, 4'd0, 4'd0, 4'd5, 4'd5, 4'd0, 4'd0};
        for (int i = 0; i < 11; i++) begin
            memReady = rdy[i]; opcode = op[i];
            #1;
            total++;
            if (state !== es[i]) begin
                bad++;
                $display("FAIL b2b_state cyc=%0d got=%0d exp=%0d", i, state, es[i]);
            end
            total++;
            if (outs !== eo[i]) begin
                bad++;
                $display("FAIL b2b_outs cyc=%0d got=%h exp=%h", i, outs, eo[i]);
            end
            if (i < 10) tick();
        end
    endtask

    task automatic test_halt_illegal();
        logic [2:0]  es  [9] = '{3'd1, 3'd2, 3'd6, 3'd6, 3'd6, 3'd1, 3'd2, 3'd7, 3'd7};
        logic [12:0] eo  [9] = '{FOK, OPL | DONE | BUSY, 13'h0, 13'h0, 13'h0, FOK,
                                 OPL | BUSY, FLT, FLT};
        logic        res [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0]  op  [9] = '{4'hF, 4'hF, 4'd0, 4'd0, 4'd0, 4'd7, 4'd7, 4'd0, 4'd0};
        for (int i = 0; i < 9; i++) begin
            memReady = 1'b1; resume = res[i]; opcode = op[i];
            #1;
            total++;
            if (state !== es[i]) begin
                bad++;
                $display("FAIL halt_state cyc=%0d got=%0d exp=%0d", i, state, es[i]);
            end
            total++;
            if (outs !== eo[i]) begin
                bad++;
                $display("FAIL halt_outs cyc=%0d got=%h exp=%h", i, outs, eo[i]);
            end
            if (i < 8) tick();
        end
        resume = 1'b0;
        clearN = 1'b0;
        tick();
        total++;
        if (state !== 3'd0 || outs !== RCLR) begin
            bad++;
            $display("FAIL halt_fault_reset state=%0d outs=%h exp state=0 outs=%h", state, outs, RCLR);
        end
        clearN = 1'b1;
        tick();
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL halt_refetch state=%0d exp=1", state);
        end
    endtask

    task automatic test_timeout();
        // Ready arriving exactly on the timeout cycle wins.
        opcode = 4'd0;
        for (int i = 0; i < 15; i++) begin
            memReady = 1'b0;
            #1;
            total++;
            if (state !== 3'd1 || outs !== (MREQ | BUSY)) begin
                bad++;
                $display("FAIL tmo_edge_wait cyc=%0d state=%0d outs=%h exp state=1 outs=%h", i, state, outs, MREQ | BUSY);
            end
            tick();
        end
        memReady = 1'b1;
        #1;
        total++;
        if (state !== 3'd1 || outs !== FOK) begin
            bad++;
            $display("FAIL tmo_edge_ready state=%0d outs=%h exp state=1 outs=%h", state, outs, FOK);
        end
        tick();
        total++;
        if (state !== 3'd2) begin
            bad++;
            $display("FAIL tmo_edge_decode state=%0d exp=2", state);
        end
        tick();
        // Full timeout: 16 FETCH cycles, then FAULT.
        for (int i = 0; i < 16; i++) begin
            memReady = 1'b0;
            #1;
            total++;
            if (state !== 3'd1 || outs !== (MREQ | BUSY)) begin
                bad++;
                $display("FAIL tmo_wait cyc=%0d state=%0d outs=%h exp state=1 outs=%h", i, state, outs, MREQ | BUSY);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            memReady = 1'b1; resume = 1'b1;
            #1;
            total++;
            if (state !== 3'd7 || outs !== FLT) begin
                bad++;
                $display("FAIL tmo_fault cyc=%0d state=%0d outs=%h exp state=7 outs=%h", i, state, outs, FLT);
            end
            tick();
        end
        resume = 1'b0;
        clearN = 1'b0;
        tick();
        clearN = 1'b1;
        tick();
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL tmo_recover state=%0d exp=1", state);
        end
    endtask

    task automatic test_reset_mid();
        memReady = 1'b1; opcode = 4'd1;
        tick();
        tick();
        tick();
        clearN = 1'b0;
        #1;
        total++;
        if (state !== 3'd5 || outs !== BUSY) begin
            bad++;
            $display("FAIL mid_wb_abort state=%0d outs=%h exp state=5 outs=%h", state, outs, BUSY);
        end
        tick();
        total++;
        if (state !== 3'd0 || outs !== RCLR) begin
            bad++;
            $display("FAIL mid_wb_reset state=%0d outs=%h exp state=0 outs=%h", state, outs, RCLR);
        end
        clearN = 1'b1;
        tick();
        clearN = 1'b0;
        #1;
        total++;
        if (state !== 3'd1 || outs !== BUSY) begin
            bad++;
            $display("FAIL mid_fetch_abort state=%0d outs=%h exp state=1 outs=%h", state, outs, BUSY);
        end
        tick();
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL mid_fetch_reset state=%0d exp=0", state);
        end
        clearN = 1'b1;
        tick();
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL mid_refetch state=%0d exp=1", state);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_branch();
        test_back_to_back();
        test_halt_illegal();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control FSM for the custom processor. It sequences instruction fetch into the instruction register, operand and ALU latching, memory access and register-file writeback. It drives the `irWrite` strobe of the instruction register and the `clear` of the plain data registers. It sits between the instruction register output (opcode field), the memory ready handshake and the datapath enables.

## Interface

Parameters:
- `opcodeWidth`, 4: width of the opcode field taken from the instruction register output.
- `waitLimit`, 15: maximum consecutive cycles the block waits for `memReady` before faulting; must be at least 1.

Ports:
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `clearN`, in, 1: synchronous, active-low reset.
- `opcode`, in, `opcodeWidth`: opcode field from the instruction register.
- `zero`, in, 1: ALU zero flag, sampled in EXEC.
- `memReady`, in, 1: memory completes the current request in this cycle.
- `resume`, in, 1: leave HALTED.
- `memReq`, out, 1: memory request.
- `memWrite`, out, 1: request is a store.
- `irWrite`, out, 1: load the instruction register.
- `pcWrite`, out, 1: update the PC.
- `pcSrcBranch`, out, 1: PC source select. 0 = PC+1, 1 = branch/jump target.
- `operandLatch`, out, 1: load the A/B operand data registers.
- `aluOutLatch`, out, 1: load the ALU output register.
- `mdrLatch`, out, 1: load the memory data register.
- `regFileWrite`, out, 1: register-file write enable.
- `regClear`, out, 1: clear for the datapath data registers.
- `instrDone`, out, 1: one-cycle pulse when an instruction retires.
- `busy`, out, 1: high in FETCH, DECODE, EXEC, MEM and WB.
- `fault`, out, 1: high in FAULT.
- `state`, out, 3: current state encoding, for debug.

## Operation

- State register and wait counter are registered. All outputs are combinational from state, the latched opcode and the inputs. Any output not listed as asserted in a state is 0.
- State encodings: RESET=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6, FAULT=7.
- Opcodes: 0 NOP, 1 ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP, all-ones HALT. Every other value is illegal.
- RESET: `regClear`=1. Goes to FETCH unconditionally on the next cycle.
- FETCH: `memReq`=1.
  - When `memReady`=1: `irWrite`=1, `pcWrite`=1, `pcSrcBranch`=0, go to DECODE.
- DECODE: `operandLatch`=1. The opcode is captured into an internal register (`curOp`); later states use `curOp`, not `opcode`.
  - NOP: `instrDone`=1, go to FETCH.
  - HALT: `instrDone`=1, go to HALTED.
  - Illegal opcode: go to FAULT.
  - Otherwise: go to EXEC.
- EXEC, by `curOp`:
  - ALU: `aluOutLatch`=1, go to WB.
  - LOAD or STORE: `aluOutLatch`=1 (address), go to MEM.
  - BRANCH: if `zero`=1, then `pcWrite`=1 and `pcSrcBranch`=1. In either case `instrDone`=1, go to FETCH.
  - JUMP: `pcWrite`=1, `pcSrcBranch`=1, `instrDone`=1, go to FETCH.
- MEM: `memReq`=1; `memWrite`=1 if `curOp` is STORE.
  - When `memReady`=1 and `curOp` is LOAD: `mdrLatch`=1, go to WB.
  - When `memReady`=1 and `curOp` is STORE: `instrDone`=1, go to FETCH.
- WB: `regFileWrite`=1, `instrDone`=1, go to FETCH.
- HALTED: all enables 0. `resume`=1 goes to FETCH.
- FAULT: `fault`=1, all enables 0. Only reset leaves FAULT.
- Wait counter:
  - Width is clog2(`waitLimit`+1).
  - Cleared on every state change and on every cycle where `memReady`=1.
  - Incremented on each FETCH or MEM cycle where `memReady`=0.
  - If the counter equals `waitLimit` and `memReady`=0, go to FAULT.

## Timing

- Reset: `clearN`=0 at a rising edge puts the block in RESET with `curOp`=0 and the counter at 0.
  - Outputs in RESET: `regClear`=1, `state`=0, every other output 0.
  - RESET repeats for as long as `clearN` stays low.
- Reset mid-operation: `clearN`=0 overrides every transition, including a `memReady` arriving in the same cycle. The aborted instruction produces no `irWrite`, `regFileWrite` or `instrDone` at that edge.
- Latency with zero-wait memory, in cycles from FETCH entry to the next FETCH:
  - NOP: 2
  - BRANCH, JUMP: 3
  - ALU, STORE: 4
  - LOAD: 5
- Each memory wait cycle adds 1 cycle.
- `memReady` is ignored outside FETCH and MEM.
- `resume` is ignored outside HALTED.
- `memReady` and timeout in the same cycle: `memReady` wins and no fault is raised.
- `irWrite` is asserted exactly once per instruction, so the instruction register holds the opcode stable from DECODE until the next fetch.

## Test plan

- Reset: hold `clearN`=0 for 3 cycles, then release. Required: `regClear`=1 and `state`=0 throughout reset and for exactly 1 cycle after release; then `state`=1 with `memReq`=1.
- ALU instruction, zero-wait memory (`memReady` held at 1), opcode 1. Required: the state sequence is 1,2,3,5,1; `irWrite` fires in cycle 1, `operandLatch` in cycle 2, `aluOutLatch` in cycle 3, `regFileWrite` and `instrDone` in cycle 4.
- LOAD with 3 wait cycles in MEM. Required: MEM lasts 4 cycles with `memReq`=1 and `memWrite`=0; `mdrLatch` pulses only on the `memReady` cycle; then WB.
- BRANCH with `zero`=0, then BRANCH with `zero`=1. Required: the first gives `pcWrite`=0 in EXEC; the second gives `pcWrite`=1 and `pcSrcBranch`=1; each completes in 3 cycles.
- Timeout: `waitLimit`=15, FETCH with `memReady` held at 0. Required: FETCH lasts 16 cycles, then FAULT with `fault`=1 and `busy`=0, held until `clearN`=0.
- HALT then resume, plus illegal opcode. Opcode all-ones: `instrDone` in DECODE, then `state`=6; `resume`=1 returns to FETCH one cycle later. Opcode 7: DECODE goes to FAULT with no `instrDone`.
